// File: rtl/panel_framebuffer_if.sv
// Host write port, swap/clear control and scanner read port of the framebuffer.
interface panel_framebuffer_if #(
    parameter int BPC = 8
);
    logic               wr_valid;
    logic               wr_ready;
    logic [4:0]         wr_x;
    logic [4:0]         wr_y;
    logic [3*BPC-1:0]   wr_rgb;
    logic               clear_req;
    logic               clear_done;
    logic               swap_req;
    logic               swap_ack;
    logic               frame_start;
    logic               front_sel;
    logic [4:0]         rd_x;
    logic [4:0]         rd_y;
    logic [2:0]         rd_z;
    logic [2:0]         rd_rgb;

    // Host / scanner side
    modport master (
        output wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req, frame_start,
               rd_x, rd_y, rd_z,
        input  wr_ready, clear_done, swap_ack, front_sel, rd_rgb
    );

    // Framebuffer side
    modport slave (
        input  wr_valid, wr_x, wr_y, wr_rgb, clear_req, swap_req, frame_start,
               rd_x, rd_y, rd_z,
        output wr_ready, clear_done, swap_ack, front_sel, rd_rgb
    );
endinterface

// File: rtl/panel_framebuffer.sv
// Double-buffered RGB framebuffer feeding a BCM LED panel scanner.
// Host writes and the clear engine target the back bank; the scanner reads
// single bit-planes from the front bank. Swaps only happen on frame_start.
module panel_framebuffer #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int BPC    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    panel_framebuffer_if.slave fb
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 3 * BPC;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              rdy_en_q;
    logic              front_sel_q;
    logic              pending_q;
    logic              swap_ack_q;
    logic              rd_bank_q;
    logic              rd_ok_q;
    logic [2:0]        rd_z_q;

    logic              wr_ready;
    logic              clr_we;
    logic              clear_done;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              swap_fire;
    logic              we;
    logic              wbank;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rd_word;
    logic [BPC-1:0]    r_sh, g_sh, b_sh;

    // Coordinate decode for both ports; out-of-range accesses never touch RAM
    always_comb begin
        wr_in_range = (int'(fb.wr_x) < WIDTH) && (int'(fb.wr_y) < HEIGHT);
        rd_in_range = (int'(fb.rd_x) < WIDTH) && (int'(fb.rd_y) < HEIGHT)
                      && (int'(fb.rd_z) < BPC);
        wr_addr = wr_in_range ? AW'(int'(fb.wr_y) * WIDTH + int'(fb.wr_x)) : '0;
        raddr   = rd_in_range ? AW'(int'(fb.rd_y) * WIDTH + int'(fb.rd_x)) : '0;
    end

    // FSM state and clear-address register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: a clear walks every back-bank address once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (fb.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: host blocked while clearing, done flagged on final address
    always_comb begin
        wr_ready   = (state_q == IDLE) && rdy_en_q;
        clr_we     = (state_q == CLEAR);
        clear_done = clr_we && (cnt_q == LAST_ADDR);
    end

    // Single write port into the back bank, shared by host and clear engine
    always_comb begin
        swap_fire = fb.frame_start && pending_q && (state_q == IDLE);
        we        = clr_we || (fb.wr_valid && wr_ready && wr_in_range);
        wbank     = ~front_sel_q;
        waddr     = clr_we ? cnt_q : wr_addr;
        wdata     = clr_we ? '0 : fb.wr_rgb;
    end

    // Swap bookkeeping, ready enable and read-side pipeline registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_en_q    <= 1'b0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            swap_ack_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
            rd_z_q      <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            swap_ack_q <= swap_fire;
            if (swap_fire) begin
                front_sel_q <= ~front_sel_q;
                pending_q   <= 1'b0;
            end else if (fb.swap_req) begin
                pending_q <= 1'b1;
            end
            // Read samples the bank that is front before this edge's swap
            rd_bank_q <= front_sel_q;
            rd_ok_q   <= rd_in_range;
            rd_z_q    <= fb.rd_z;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DW-1:0] mem [DEPTH];
            logic [DW-1:0] rd_word_q;

            // Block RAM bank: one write port, one registered read port
            always_ff @(posedge clk_i) begin
                if (we && (wbank == 1'(gi))) begin
                    mem[waddr] <= wdata;
                end
                rd_word_q <= mem[raddr];
            end
        end
    endgenerate

    // Bit-plane extraction from the registered front-bank word
    always_comb begin
        rd_word = rd_bank_q ? g_bank[1].rd_word_q : g_bank[0].rd_word_q;
        r_sh    = rd_word[3*BPC-1 -: BPC] >> rd_z_q;
        g_sh    = rd_word[2*BPC-1 -: BPC] >> rd_z_q;
        b_sh    = rd_word[BPC-1 -: BPC] >> rd_z_q;
    end

    assign fb.wr_ready   = wr_ready;
    assign fb.clear_done = clear_done;
    assign fb.swap_ack   = swap_ack_q;
    assign fb.front_sel  = front_sel_q;
    assign fb.rd_rgb     = rd_ok_q ? {r_sh[0], g_sh[0], b_sh[0]} : 3'b000;
endmodule

// File: tb/tb_panel_framebuffer.sv
// Scoreboard bench for panel_framebuffer: a pixel-array model predicts every
// cycle's outputs at the clock edge; a negedge monitor pops and compares.
module tb_panel_framebuffer;
    localparam int W     = 32;
    localparam int H     = 24;
    localparam int B     = 6;
    localparam int DEPTH = W * H;

    typedef struct {
        logic [2:0] rgb;
        bit         rgb_chk;
        bit         rdy;
        bit         ack;
        bit         done;
        bit         fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    panel_framebuffer_if #(.BPC(B)) ifc ();

    panel_framebuffer #(.WIDTH(W), .HEIGHT(H), .BPC(B)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .fb    (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: two pixel arrays plus swap/clear status
    logic [3*B-1:0] m_mem   [2][DEPTH];
    bit             m_known [2][DEPTH];
    bit             m_front, m_pend, m_clr, m_rdy, m_fire, m_oldclr;
    int             m_cnt, m_a, m_z;
    logic [3*B-1:0] m_px, m_sh;
    exp_t           m_e;

    function automatic logic [3*B-1:0] mk(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
        return {r[B-1:0], g[B-1:0], b[B-1:0]};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: predict outputs visible after this edge from the inputs before it
    always @(posedge clk) begin
        if (rst) begin
            m_front = 0; m_pend = 0; m_clr = 0; m_cnt = 0; m_rdy = 0;
            m_e = '{rgb: 3'b000, rgb_chk: 1'b1, rdy: 1'b0, ack: 1'b0, done: 1'b0, fs: 1'b0};
        end else begin
            m_e.rgb = 3'b000;
            m_e.rgb_chk = 1'b1;
            m_z = int'(ifc.rd_z);
            if (int'(ifc.rd_x) < W && int'(ifc.rd_y) < H && m_z < B) begin
                m_a = int'(ifc.rd_y) * W + int'(ifc.rd_x);
                if (!m_known[m_front][m_a]) begin
                    m_e.rgb_chk = 1'b0;
                end else begin
                    m_px = m_mem[m_front][m_a];
                    m_sh = m_px >> (2 * B + m_z); m_e.rgb[2] = m_sh[0];
                    m_sh = m_px >> (B + m_z);     m_e.rgb[1] = m_sh[0];
                    m_sh = m_px >> m_z;           m_e.rgb[0] = m_sh[0];
                end
            end
            m_oldclr = m_clr;
            if (m_rdy && !m_clr && ifc.wr_valid &&
                int'(ifc.wr_x) < W && int'(ifc.wr_y) < H) begin
                m_a = int'(ifc.wr_y) * W + int'(ifc.wr_x);
                m_mem[!m_front][m_a] = ifc.wr_rgb;
                m_known[!m_front][m_a] = 1'b1;
            end
            if (m_oldclr) begin
                m_mem[!m_front][m_cnt] = '0;
                m_known[!m_front][m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == DEPTH) m_clr = 0;
            end else if (ifc.clear_req) begin
                m_clr = 1; m_cnt = 0;
            end
            m_fire = ifc.frame_start && m_pend && !m_oldclr;
            if (m_fire) begin
                m_front = !m_front; m_pend = 0;
            end else if (ifc.swap_req) begin
                m_pend = 1;
            end
            m_rdy = 1;
            m_e.rdy  = m_rdy && !m_clr;
            m_e.ack  = m_fire;
            m_e.done = m_clr && (m_cnt == DEPTH - 1);
            m_e.fs   = m_front;
        end
        exp_q.push_back(m_e);
    end

    // Monitor: compare every cycle's outputs against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst) begin
                check("wr_ready", {2'b00, ifc.wr_ready}, {2'b00, e.rdy});
                check("swap_ack", {2'b00, ifc.swap_ack}, {2'b00, e.ack});
                check("clear_done", {2'b00, ifc.clear_done}, {2'b00, e.done});
                check("front_sel", {2'b00, ifc.front_sel}, {2'b00, e.fs});
                if (e.rgb_chk) check("rd_rgb", ifc.rd_rgb, e.rgb);
                if (e.ack) $display("swap t=%0t front_sel=%0d", $time, ifc.front_sel);
                if (e.done) $display("clear_done t=%0t", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ifc.wr_valid = 1'b0; ifc.clear_req = 1'b0; ifc.swap_req = 1'b0;
        ifc.frame_start = 1'b0; ifc.rd_y = 5'(H); ifc.rd_x = '0; ifc.rd_z = '0;
    endtask

    task automatic rd(input int x, input int y, input int z);
        ifc.rd_x = 5'(x); ifc.rd_y = 5'(y); ifc.rd_z = 3'(z);
        tick();
    endtask

    task automatic wr(input int x, input int y, input logic [3*B-1:0] v);
        ifc.wr_valid = 1'b1; ifc.wr_x = 5'(x); ifc.wr_y = 5'(y); ifc.wr_rgb = v;
    endtask

    task automatic do_swap();
        ifc.swap_req = 1'b1; tick();
        ifc.frame_start = 1'b1; tick();
    endtask

    initial begin
        ifc.wr_valid = 1'b0; ifc.wr_x = '0; ifc.wr_y = '0; ifc.wr_rgb = '0;
        ifc.clear_req = 1'b0; ifc.swap_req = 1'b0; ifc.frame_start = 1'b0;
        ifc.rd_x = '0; ifc.rd_y = 5'(H); ifc.rd_z = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single pixel, swap, bit-plane walk including out-of-range planes
        wr(3, 5, mk(8'hA5, 8'h00, 8'hFF)); tick();
        do_swap();
        for (int z = 0; z < 8; z++) rd(3, 5, z);

        // Several requests merge into one swap; a second frame_start is idle
        for (int i = 0; i < 4; i++) begin ifc.swap_req = 1'b1; tick(); end
        ifc.frame_start = 1'b1; tick(); tick(); tick();
        ifc.frame_start = 1'b1; tick(); tick();

        // Fill back with ones, clear it, swap, random reads return zero
        for (int a = 0; a < DEPTH; a++) begin wr(a % W, a / W, '1); tick(); end
        ifc.clear_req = 1'b1; tick();
        repeat (DEPTH + 2) tick();
        do_swap();
        for (int i = 0; i < 60; i++)
            rd($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7));

        // frame_start during a clear is deferred until the clear finishes
        ifc.clear_req = 1'b1; ifc.swap_req = 1'b1; tick();
        repeat (99) tick();
        ifc.frame_start = 1'b1; tick();
        repeat (DEPTH + 3) tick();
        ifc.frame_start = 1'b1; tick(); tick();

        // Write and clear_req together: clear wins; out-of-range reads give zero
        wr(0, 0, '1); ifc.clear_req = 1'b1; tick();
        repeat (DEPTH + 2) tick();
        do_swap();
        for (int z = 0; z < 8; z++) rd(0, 0, z);
        rd(0, H + 3, 0);

        // Randomised traffic on all ports
        for (int i = 0; i < 4000; i++) begin
            ifc.wr_valid = 1'($urandom_range(0, 1));
            ifc.wr_x = 5'($urandom); ifc.wr_y = 5'($urandom);
            ifc.wr_rgb = (3*B)'($urandom);
            ifc.clear_req = ($urandom_range(0, 499) == 0);
            ifc.swap_req = ($urandom_range(0, 19) == 0);
            ifc.frame_start = ($urandom_range(0, 14) == 0);
            ifc.rd_x = 5'($urandom); ifc.rd_y = 5'($urandom); ifc.rd_z = 3'($urandom);
            tick();
        end
        repeat (DEPTH + 2) tick();

        // Reset in the middle of a clear with a swap pending
        ifc.clear_req = 1'b1; ifc.swap_req = 1'b1; tick();
        repeat (499) tick();
        rst = 1'b1;
        #2;
        check("rst_wr_ready", {2'b00, ifc.wr_ready}, 3'b000);
        check("rst_front_sel", {2'b00, ifc.front_sel}, 3'b000);
        check("rst_swap_ack", {2'b00, ifc.swap_ack}, 3'b000);
        check("rst_clear_done", {2'b00, ifc.clear_done}, 3'b000);
        check("rst_rd_rgb", ifc.rd_rgb, 3'b000);
        tick(); tick();
        rst = 1'b0;
        tick();
        ifc.frame_start = 1'b1; tick();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
